// File: rtl/twiddle_ram_writer.sv
// twiddle_ram_writer
// Streams DEPTH signed coefficient words from a valid/ready source into RAM
// port A (dia/addra/cea). Writes go to base_addr, base_addr+1, ... and the
// address wraps modulo 2^ADDR_W. A load can be aborted while it is running.
// Optional feature: define TW_CHECKSUM_EN to build a running checksum of the
// written words; without it checksum is tied to zero.
module twiddle_ram_writer #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic        [ADDR_W-1:0]         base_addr,
   input  logic                             abort,
   input  logic signed [DATA_W-1:0]         in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic signed [DATA_W-1:0]         dia,
   output logic        [ADDR_W-1:0]         addra,
   output logic                             cea,
   output logic                             busy,
   output logic                             done,
   output logic signed [DATA_W+ADDR_W-1:0]  checksum
);

   localparam int CS_W = DATA_W + ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Word index of the last beat of a load.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] count;
   logic              rst_ok;
   logic              beat;

   // Reset release is taken up one clock late so the FSM never acts on the
   // edge where reset is released; the first start counts on the next edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_ok <= 1'b0;
      else      rst_ok <= 1'b1;
   end

   // An abort in the same cycle as a beat drops that beat.
   assign in_ready = (state == S_LOAD);
   assign beat     = in_ready && in_valid && !abort;
   assign busy     = (state == S_LOAD);
   // DONE lasts exactly one cycle, which is the cycle the final word is on port A.
   assign done     = (state == S_DONE);

   // Load sequencing: IDLE -> LOAD on start, LOAD -> DONE on the last beat,
   // LOAD -> IDLE on abort, DONE -> IDLE unconditionally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         base  <= '0;
         count <= '0;
      end else if (rst_ok) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  base  <= base_addr;
                  count <= '0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (in_valid) begin
                  if (count == LAST) state <= S_DONE;
                  else               count <= count + ADDR_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // RAM port A register: one-cycle latency from accepted beat to write strobe;
   // data and address hold between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dia   <= '0;
         addra <= '0;
         cea   <= 1'b0;
      end else begin
         cea <= beat;
         if (beat) begin
            dia   <= in_data;
            addra <= base + count;
         end
      end
   end

`ifdef TW_CHECKSUM_EN
   logic signed [CS_W-1:0] acc;

   function automatic logic signed [CS_W-1:0] sext(input logic signed [DATA_W-1:0] x);
      return {{ADDR_W{x[DATA_W-1]}}, x};
   endfunction

   // Accumulate on acceptance so the sum already includes the final word in
   // the cycle done is high; the sum wraps and survives an abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (rst_ok) begin
         if (state == S_IDLE && start) acc <= '0;
         else if (beat)                acc <= acc + sext(in_data);
      end
   end

   assign checksum = acc;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_twiddle_ram_writer.sv
// Self-checking bench for twiddle_ram_writer: table-driven load scenarios
// with a write scoreboard, plus hand sequences for reset and DEPTH=1.
module tb_twiddle_ram_writer;

   localparam int DATA_W = 18;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 8;
   localparam int CS_W   = DATA_W + ADDR_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst = 1'b0;
   logic                     start = 1'b0;
   logic                     abort = 1'b0;
   logic                     in_valid = 1'b0;
   logic        [ADDR_W-1:0] base_addr = '0;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     in_ready, cea, busy, done;
   logic signed [DATA_W-1:0] dia;
   logic        [ADDR_W-1:0] addra;
   logic signed [CS_W-1:0]   checksum;

   logic                     start1 = 1'b0;
   logic                     abort1 = 1'b0;
   logic                     valid1 = 1'b0;
   logic        [ADDR_W-1:0] base1 = '0;
   logic signed [DATA_W-1:0] data1 = '0;
   logic                     ready1, cea1, busy1, done1;
   logic signed [DATA_W-1:0] dia1;
   logic        [ADDR_W-1:0] addra1;
   logic signed [CS_W-1:0]   cs1;

   twiddle_ram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .dia(dia),
      .addra(addra), .cea(cea), .busy(busy), .done(done), .checksum(checksum));

   twiddle_ram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .abort(abort1),
      .in_data(data1), .in_valid(valid1), .in_ready(ready1), .dia(dia1),
      .addra(addra1), .cea(cea1), .busy(busy1), .done(done1), .checksum(cs1));

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        [ADDR_W-1:0] addr;
      logic signed [DATA_W-1:0] data;
      logic                     dn;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      int                       grp;
      logic        [ADDR_W-1:0] base;
      logic                     st;
      logic                     vld;
      logic                     abt;
      logic signed [DATA_W-1:0] data;
      logic                     exp_wr;
      logic        [ADDR_W-1:0] exp_addr;
      logic                     exp_done;
   } vec_t;
   vec_t tbl[$];

   longint                 cs_model;
   logic signed [CS_W-1:0] cs_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dia"},      64'(dia),      64'(0));
      chk({tag, "_addra"},    64'(addra),    64'(0));
      chk({tag, "_cea"},      64'(cea),      64'(0));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "_busy"},     64'(busy),     64'(0));
      chk({tag, "_done"},     64'(done),     64'(0));
      chk({tag, "_checksum"}, 64'(checksum), 64'(0));
   endtask

   task automatic add(input int g, input int b, input logic st, input logic vl, input logic ab,
                      input int d, input logic wr, input int a, input logic dn);
      vec_t v;
      v.grp = g; v.base = ADDR_W'(b); v.st = st; v.vld = vl; v.abt = ab;
      v.data = DATA_W'(d); v.exp_wr = wr; v.exp_addr = ADDR_W'(a); v.exp_done = dn;
      tbl.push_back(v);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b);
      chk("ready_idle", 64'(in_ready), 64'(0));
      start = 1'b1; base_addr = b;
      @(negedge clk);
      start = 1'b0; base_addr = '0;
      chk("busy_load", 64'(busy), 64'(1));
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (rst) begin
         if (cea) begin
            if (exp_q.size() == 0) begin
               tests++; failed++;
               $display("FAIL unexpected_write: addra=%0d dia=%0d, no write expected", addra, dia);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(addra), 64'(e.addr));
               chk("wr_data", 64'(dia),   64'(e.data));
               chk("wr_done", 64'(done),  64'(e.dn));
            end
         end else if (done) begin
            chk("done_without_write", 64'(done), 64'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int   d1[8] = '{-25079, -46340, -60547, 0, 1, 2, 3, 4};
      int   prev;
      logic last;
      vec_t v;

      // group 1: nominal load from address 0
      for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, d1[i], 1, i, i == 7);
      // group 2: valid toggling, one start pulse issued mid-load
      for (int j = 0; j < 15; j++) begin
         logic vl;
         vl = (j % 2 == 0);
         add(2, 16, j == 3, vl, 0, vl ? 100 + j / 2 : 7, vl, 16 + j / 2, vl && (j / 2 == 7));
      end
      // group 3: address wrap at the top of the RAM
      for (int i = 0; i < 8; i++) add(3, 510, 0, 1, 0, -1000 * i, 1, (510 + i) % 512, i == 7);
      // group 4: abort offered with the 4th beat
      for (int i = 0; i < 3; i++) add(4, 0, 0, 1, 0, 500 + i, 1, i, 0);
      add(4, 0, 0, 1, 1, 999, 0, 0, 0);
      // group 5: normal reload after abort
      for (int i = 0; i < 8; i++) add(5, 0, 0, 1, 0, -7 * (i + 1), 1, i, i == 7);
      // group 6: abort together with the final beat
      for (int i = 0; i < 7; i++) add(6, 100, 0, 1, 0, i + 10, 1, 100 + i, 0);
      add(6, 100, 0, 1, 1, 77, 0, 0, 0);

      // reset state, with start held during reset
      start = 1'b1; base_addr = 9'd5;
      repeat (2) @(negedge clk);
      chk_zero("reset");

      // release: first edge after release ignores start, second edge honours it
      rst = 1'b1;
      @(negedge clk);
      chk("rel_edge1_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("rel_edge2_busy", 64'(busy), 64'(1));
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("rel_abort_busy", 64'(busy), 64'(0));
      @(negedge clk);

      prev = 0;
      cs_model = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         if (v.grp != prev) begin
            do_start(v.base);
            cs_model = 0;
            prev = v.grp;
         end
         chk("in_ready_load", 64'(in_ready), 64'(1));
         start = v.st; base_addr = v.st ? 9'd300 : 9'd77;
         in_valid = v.vld; abort = v.abt; in_data = v.data;
         if (v.exp_wr) begin
            exp_q.push_back('{addr: v.exp_addr, data: v.data, dn: v.exp_done});
            cs_model += longint'(v.data);
         end
         @(negedge clk);
         start = 1'b0; in_valid = 1'b0; abort = 1'b0;
         last = (i == tbl.size() - 1) || (tbl[i+1].grp != v.grp);
         if (last) begin
`ifdef TW_CHECKSUM_EN
            cs_exp = CS_W'(cs_model);
`else
            cs_exp = '0;
`endif
            chk("busy_end", 64'(busy), 64'(0));
            chk("done_end", 64'(done), 64'(v.exp_done));
            chk("checksum_end", 64'(checksum), 64'(cs_exp));
            if (v.exp_done) begin
               start = 1'b1; base_addr = 9'd50; abort = 1'b1;
            end
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            chk("busy_idle", 64'(busy), 64'(0));
            chk("done_idle", 64'(done), 64'(0));
            chk("checksum_hold", 64'(checksum), 64'(cs_exp));
            @(negedge clk);
            chk("pending_writes", 64'(exp_q.size()), 64'(0));
         end
      end

      // reset in the middle of a load after three writes
      do_start(9'd0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{addr: ADDR_W'(i), data: DATA_W'(i + 40), dn: 1'b0});
         in_valid = 1'b1; in_data = DATA_W'(i + 40);
         @(negedge clk);
      end
      in_data = DATA_W'(99);
      #2 rst = 1'b0;
      #1 chk_zero("midload_reset");
      @(negedge clk);
      in_valid = 1'b0;
      chk_zero("midload_held");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_busy", 64'(busy), 64'(0));
      chk("post_reset_done", 64'(done), 64'(0));
      chk("post_reset_pending", 64'(exp_q.size()), 64'(0));

      // DEPTH=1: one beat completes the load
      start1 = 1'b1; base1 = 9'd33;
      @(negedge clk);
      start1 = 1'b0; base1 = '0;
      chk("d1_busy", 64'(busy1), 64'(1));
      valid1 = 1'b1; data1 = -18'sd5;
      @(negedge clk);
      valid1 = 1'b0;
`ifdef TW_CHECKSUM_EN
      cs_exp = -27'sd5;
`else
      cs_exp = '0;
`endif
      chk("d1_cea",   64'(cea1),   64'(1));
      chk("d1_addr",  64'(addra1), 64'(33));
      chk("d1_data",  64'(dia1),   64'(-18'sd5));
      chk("d1_done",  64'(done1),  64'(1));
      chk("d1_busy_done", 64'(busy1), 64'(0));
      chk("d1_checksum", 64'(cs1), 64'(cs_exp));
      @(negedge clk);
      chk("d1_cea_after",  64'(cea1),  64'(0));
      chk("d1_done_after", 64'(done1), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
